// File: rtl/laser_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : laser_host_ctrl
// Brief    : Host-side driver for the LASER two-circle coverage engine; buffers
//            a point pattern, streams it to LASER, captures and scores C1/C2.
//            Optional RUN_CYC output enabled by LASER_HOST_CYCCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module laser_host_ctrl #(
    parameter int NPTS     = 40,
    parameter int LRST_CYC = 2,
    parameter int MAX_CYC  = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_EN,
    input  logic [3:0]  WR_X,
    input  logic [3:0]  WR_Y,
    input  logic        START,
    output logic        BUSY,
    output logic        LRST,
    output logic [3:0]  LX,
    output logic [3:0]  LY,
    input  logic        DONE_I,
    input  logic [3:0]  C1X_I,
    input  logic [3:0]  C1Y_I,
    input  logic [3:0]  C2X_I,
    input  logic [3:0]  C2Y_I,
    output logic [3:0]  RES_C1X,
    output logic [3:0]  RES_C1Y,
    output logic [3:0]  RES_C2X,
    output logic [3:0]  RES_C2Y,
    output logic [5:0]  COVER,
    output logic        FIN,
    output logic        TMO,
`ifdef LASER_HOST_CYCCNT_EN
    output logic [16:0] RUN_CYC,
`endif
    output logic        ERR
);

    localparam int          c_IW        = $clog2(NPTS + 1);
    localparam logic [c_IW-1:0] c_FULL  = c_IW'(NPTS);
    localparam logic [c_IW-1:0] c_LAST  = c_IW'(NPTS - 1);
    localparam logic [16:0] c_LRST_LAST = 17'(LRST_CYC - 1);
    localparam logic [16:0] c_MAX       = 17'(MAX_CYC);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LRST   = 3'd1;
    localparam logic [2:0] c_S_STREAM = 3'd2;
    localparam logic [2:0] c_S_RUN    = 3'd3;
    localparam logic [2:0] c_S_SCORE  = 3'd4;
    localparam logic [2:0] c_S_REPORT = 3'd5;

    logic [2:0]      r_state;
    logic [c_IW-1:0] r_wptr;
    logic [c_IW-1:0] r_idx;
    logic [16:0]     r_cyc;
    logic [7:0]      r_buf [0:NPTS-1];
    logic            r_lrst;
    logic [3:0]      r_lx;
    logic [3:0]      r_ly;
    logic [3:0]      r_c1x;
    logic [3:0]      r_c1y;
    logic [3:0]      r_c2x;
    logic [3:0]      r_c2y;
    logic [5:0]      r_cover;
    logic            r_fin;
    logic            r_tmo;
    logic            r_err;
`ifdef LASER_HOST_CYCCNT_EN
    logic [16:0]     r_run_cyc;
`endif

    logic [c_IW-1:0] w_nidx;
    logic [3:0]      w_px;
    logic [3:0]      w_py;
    logic [7:0]      w_d1;
    logic [7:0]      w_d2;
    logic            w_hit;
    logic            w_wr;

    function automatic logic [7:0] sq_abs(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return {4'd0, d} * {4'd0, d};
    endfunction

    assign w_nidx = r_idx + 1'b1;
    assign w_px   = r_buf[r_idx][7:4];
    assign w_py   = r_buf[r_idx][3:0];
    // Distance is carried in 8 bits; the sum is allowed to wrap.
    assign w_d1   = sq_abs(w_px, r_c1x) + sq_abs(w_py, r_c1y);
    assign w_d2   = sq_abs(w_px, r_c2x) + sq_abs(w_py, r_c2y);
    assign w_hit  = (w_d1 <= 8'd16) || (w_d2 <= 8'd16);
    assign w_wr   = (r_state == c_S_IDLE) && WR_EN && (r_wptr != c_FULL);

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_buf[r_wptr] <= {WR_X, WR_Y};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_S_IDLE;
            r_wptr    <= '0;
            r_idx     <= '0;
            r_cyc     <= '0;
            r_lrst    <= 1'b0;
            r_lx      <= 4'd0;
            r_ly      <= 4'd0;
            r_c1x     <= 4'd0;
            r_c1y     <= 4'd0;
            r_c2x     <= 4'd0;
            r_c2y     <= 4'd0;
            r_cover   <= 6'd0;
            r_fin     <= 1'b0;
            r_tmo     <= 1'b0;
            r_err     <= 1'b0;
`ifdef LASER_HOST_CYCCNT_EN
            r_run_cyc <= 17'd0;
`endif
        end else begin
            r_fin <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_wr) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (START && (r_wptr == c_FULL)) begin
                        r_state <= c_S_LRST;
                        r_lrst  <= 1'b1;
                        r_cyc   <= 17'd0;
                        r_tmo   <= 1'b0;
                        r_err   <= 1'b0;
                        r_cover <= 6'd0;
                    end
                end
                c_S_LRST: begin
                    if (r_cyc == c_LRST_LAST) begin
                        r_state <= c_S_STREAM;
                        r_lrst  <= 1'b0;
                        r_idx   <= '0;
                        r_lx    <= r_buf[0][7:4];
                        r_ly    <= r_buf[0][3:0];
                    end else begin
                        r_cyc <= r_cyc + 17'd1;
                    end
                end
                c_S_STREAM: begin
                    // LASER finishing while still being fed is a protocol error.
                    if (DONE_I) begin
                        r_err   <= 1'b1;
                        r_fin   <= 1'b1;
                        r_cover <= 6'd0;
                        r_wptr  <= '0;
                        r_state <= c_S_IDLE;
                    end else if (r_idx == c_LAST) begin
                        r_state <= c_S_RUN;
                        r_cyc   <= 17'd0;
                    end else begin
                        r_idx <= w_nidx;
                        r_lx  <= r_buf[w_nidx][7:4];
                        r_ly  <= r_buf[w_nidx][3:0];
                    end
                end
                c_S_RUN: begin
                    if (DONE_I || (r_cyc == c_MAX)) begin
                        r_c1x   <= C1X_I;
                        r_c1y   <= C1Y_I;
                        r_c2x   <= C2X_I;
                        r_c2y   <= C2Y_I;
                        r_tmo   <= ~DONE_I;
                        r_idx   <= '0;
                        r_state <= c_S_SCORE;
`ifdef LASER_HOST_CYCCNT_EN
                        r_run_cyc <= r_cyc + 17'd1;
`endif
                    end else begin
                        r_cyc <= r_cyc + 17'd1;
                    end
                end
                c_S_SCORE: begin
                    r_cover <= r_cover + {5'd0, w_hit};
                    if (r_idx == c_LAST) begin
                        r_state <= c_S_REPORT;
                        r_fin   <= 1'b1;
                    end else begin
                        r_idx <= w_nidx;
                    end
                end
                c_S_REPORT: begin
                    r_wptr  <= '0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign BUSY    = (r_state != c_S_IDLE);
    assign LRST    = r_lrst;
    assign LX      = r_lx;
    assign LY      = r_ly;
    assign RES_C1X = r_c1x;
    assign RES_C1Y = r_c1y;
    assign RES_C2X = r_c2x;
    assign RES_C2Y = r_c2y;
    assign COVER   = r_cover;
    assign FIN     = r_fin;
    assign TMO     = r_tmo;
    assign ERR     = r_err;
`ifdef LASER_HOST_CYCCNT_EN
    assign RUN_CYC = r_run_cyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_laser_host_ctrl.sv
`default_nettype none
// Directed testbench for laser_host_ctrl: load, stream, score, error and timeout paths.
module tb_laser_host_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_EN = 1'b0;
    logic [3:0]  WR_X = 4'd0;
    logic [3:0]  WR_Y = 4'd0;
    logic        START = 1'b0;
    logic        BUSY;
    logic        LRST;
    logic [3:0]  LX;
    logic [3:0]  LY;
    logic        DONE_I = 1'b0;
    logic [3:0]  C1X_I = 4'd0;
    logic [3:0]  C1Y_I = 4'd0;
    logic [3:0]  C2X_I = 4'd0;
    logic [3:0]  C2Y_I = 4'd0;
    logic [3:0]  RES_C1X;
    logic [3:0]  RES_C1Y;
    logic [3:0]  RES_C2X;
    logic [3:0]  RES_C2Y;
    logic [5:0]  COVER;
    logic        FIN;
    logic        TMO;
    logic        ERR;
`ifdef LASER_HOST_CYCCNT_EN
    logic [16:0] RUN_CYC;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] pts [40];

    laser_host_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR_EN   (WR_EN),
        .WR_X    (WR_X),
        .WR_Y    (WR_Y),
        .START   (START),
        .BUSY    (BUSY),
        .LRST    (LRST),
        .LX      (LX),
        .LY      (LY),
        .DONE_I  (DONE_I),
        .C1X_I   (C1X_I),
        .C1Y_I   (C1Y_I),
        .C2X_I   (C2X_I),
        .C2Y_I   (C2Y_I),
        .RES_C1X (RES_C1X),
        .RES_C1Y (RES_C1Y),
        .RES_C2X (RES_C2X),
        .RES_C2Y (RES_C2Y),
        .COVER   (COVER),
        .FIN     (FIN),
        .TMO     (TMO),
`ifdef LASER_HOST_CYCCNT_EN
        .RUN_CYC (RUN_CYC),
`endif
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0: all (8,8); 1: 12 near (3,3) + 9 near (12,12) + far; 2: distance boundary set
    task automatic fill(input int set);
        logic [7:0] s1 [21];
        logic [7:0] s2 [6];
        s1 = '{8'h33, 8'h43, 8'h34, 8'h23, 8'h32, 8'h44, 8'h22, 8'h53, 8'h35, 8'h13, 8'h31, 8'h73,
               8'hCC, 8'hDC, 8'hCD, 8'hBC, 8'hCB, 8'hDD, 8'hBB, 8'hEC, 8'hCE};
        s2 = '{8'h73, 8'h74, 8'h33, 8'h44, 8'h22, 8'h35};
        for (int i = 0; i < 40; i++) begin
            if (set == 0) begin
                pts[i] = 8'h88;
            end else if (set == 1) begin
                if (i < 21)      pts[i] = s1[i];
                else if (i < 28) pts[i] = 8'h88;
                else if (i < 34) pts[i] = 8'hF0;
                else             pts[i] = 8'h0F;
            end else begin
                if (i < 6)           pts[i] = s2[i];
                else if (i % 2 == 0) pts[i] = 8'h88;
                else                 pts[i] = 8'hF0;
            end
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            WR_EN = 1'b1;
            WR_X  = pts[i][7:4];
            WR_Y  = pts[i][3:0];
            step();
        end
        WR_EN = 1'b0;
    endtask

    task automatic set_c(input logic [15:0] c);
        {C1X_I, C1Y_I, C2X_I, C2Y_I} = c;
    endtask

    // run_cycles = 0 means DONE never arrives (timeout run)
    task automatic do_run(input int run_cycles, input int exp_cover, input logic [15:0] exp_res,
                          input logic exp_tmo, input bit wr_in_stream);
        int lcnt;
        int n;
        START = 1'b1;
        step();
        START = 1'b0;
        chk("busy_after_start", BUSY, 1);
        chk("err_cleared", ERR, 0);
        chk("tmo_cleared", TMO, 0);
        lcnt = 0;
        while (LRST === 1'b1 && lcnt < 10) begin
            lcnt++;
            step();
        end
        chk("lrst_len", lcnt, 2);
        for (int k = 0; k < 40; k++) begin
            chk("stream_pt", {LX, LY}, pts[k]);
            if (wr_in_stream) begin
                WR_EN = 1'b1;
                WR_X  = 4'(k);
                WR_Y  = ~4'(k);
            end
            step();
        end
        WR_EN = 1'b0;
        chk("run_hold_pt", {LX, LY}, pts[39]);
        if (run_cycles > 0) begin
            for (int r = 1; r < run_cycles; r++) step();
            DONE_I = 1'b1;
            step();
            DONE_I = 1'b0;
        end
        n = 0;
        while (FIN !== 1'b1 && n < 60000) begin
            n++;
            step();
        end
        chk("cycles_to_fin", n, (run_cycles > 0) ? 40 : 50041);
        chk("fin", FIN, 1);
        chk("cover", COVER, exp_cover);
        chk("res", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, exp_res);
        chk("tmo", TMO, exp_tmo);
        chk("err", ERR, 0);
`ifdef LASER_HOST_CYCCNT_EN
        chk("run_cyc", RUN_CYC, (run_cycles > 0) ? run_cycles : 50001);
`endif
        step();
        chk("fin_one_cycle", FIN, 0);
        chk("idle_after_report", BUSY, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", BUSY, 0);
        chk("rst_lrst", LRST, 0);
        chk("rst_lxy", {LX, LY}, 0);
        chk("rst_res", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, 0);
        chk("rst_flags", {COVER, FIN, TMO, ERR}, 0);
        RST = 1'b0;
        step();

        // Uniform pattern, full cover by C1
        fill(0);
        load(40);
        set_c(16'h8800);
        do_run(100, 40, 16'h8800, 1'b0, 1'b0);

        // Two disjoint clusters
        fill(1);
        load(40);
        set_c(16'h33CC);
        do_run(37, 21, 16'h33CC, 1'b0, 1'b0);

        // d=16 counts, d=17 does not, C1==C2 counted once
        fill(2);
        load(40);
        set_c(16'h3333);
        do_run(5, 5, 16'h3333, 1'b0, 1'b0);

        // DONE during STREAM at k=5
        fill(0);
        load(40);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        chk("err_run_lrst_low", LRST, 0);
        for (int k = 0; k < 5; k++) step();
        chk("err_run_k5", {BUSY, ERR}, 2'b10);
        DONE_I = 1'b1;
        step();
        chk("err_set", ERR, 1);
        chk("err_fin", FIN, 1);
        chk("err_cover", COVER, 0);
        chk("err_idle", BUSY, 0);
        DONE_I = 1'b0;
        step();
        chk("err_fin_pulse", FIN, 0);
        chk("err_sticky", ERR, 1);
        START = 1'b1;
        step();
        START = 1'b0;
        chk("err_wptr_cleared", BUSY, 0);

        // 39 points: START ignored; then 40th point and WR_EN during STREAM
        fill(1);
        load(39);
        START = 1'b1;
        step();
        START = 1'b0;
        chk("start39_busy", BUSY, 0);
        chk("start39_lrst", LRST, 0);
        step();
        chk("start39_still_idle", BUSY, 0);
        WR_EN = 1'b1;
        WR_X  = pts[39][7:4];
        WR_Y  = pts[39][3:0];
        step();
        WR_EN = 1'b0;
        set_c(16'h33CC);
        do_run(12, 21, 16'h33CC, 1'b0, 1'b1);

        // Timeout: DONE never arrives, score from the present C*_I
        fill(1);
        load(40);
        set_c(16'h33CC);
        do_run(0, 21, 16'h33CC, 1'b1, 1'b0);

        // Reset from IDLE clears held results and sticky flags
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst2_res", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, 0);
        chk("rst2_cover", COVER, 0);
        chk("rst2_tmo", TMO, 0);

        // Reset during LRST drops LRST
        fill(2);
        load(40);
        START = 1'b1;
        step();
        START = 1'b0;
        chk("lrst_high", LRST, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_lrst_drop", LRST, 0);
        chk("rst_lrst_idle", BUSY, 0);

        // Reset during RUN, after a completed run left results behind
        set_c(16'h3333);
        load(40);
        do_run(3, 5, 16'h3333, 1'b0, 1'b0);
        load(40);
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 52; i++) step();
        chk("midrun_busy", BUSY, 1);
        chk("midrun_lxy", {LX, LY}, pts[39]);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst3_busy", BUSY, 0);
        chk("rst3_lrst", LRST, 0);
        chk("rst3_lxy", {LX, LY}, 0);
        chk("rst3_res", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, 0);
        chk("rst3_flags", {COVER, FIN, TMO, ERR}, 0);

        // Reload and rerun after reset
        fill(1);
        load(40);
        set_c(16'h33CC);
        do_run(100, 21, 16'h33CC, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/laser_host_ctrl.md
Name: laser_host_ctrl

Overview:
- Host-side driver for the LASER two-circle coverage engine; owns the other end of its point-stream / DONE interface.
- Buffers 40 points written by a host, resets LASER, streams the points one per cycle, then waits for DONE.
- On DONE it captures C1/C2 and scores them sequentially, counting points within radius 4 of either centre.
- Reports the result and cover count, so the full system can run on silicon without a testbench.

Parameters:
- NPTS, 40, number of points per pattern.
- LRST_CYC, 2, cycles LRST is held high before streaming.
- MAX_CYC, 50000, RUN-state cycle limit before forced capture.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- WR_EN  in  1  write one point into the buffer.
- WR_X  in  4  point X coordinate.
- WR_Y  in  4  point Y coordinate.
- START  in  1  begin a run; single-cycle pulse.
- BUSY  out  1  high in every state except IDLE.
- LRST  out  1  reset output to LASER.
- LX  out  4  point X to LASER.
- LY  out  4  point Y to LASER.
- DONE_I  in  1  LASER DONE.
- C1X_I, C1Y_I, C2X_I, C2Y_I  in  4 each  LASER result.
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured result.
- COVER  out  6  number of covered points, 0..40.
- FIN  out  1  one-cycle pulse when the result is valid.
- TMO  out  1  sticky: last run hit MAX_CYC.
- ERR  out  1  sticky: DONE_I seen high during STREAM.

Behaviour:
- Reset: state=IDLE, wptr=0, LRST=0, LX=LY=0, all RES_*=0, COVER=0, FIN=0, TMO=0, ERR=0, BUSY=0. Buffer contents are don't-care.
- Loading (IDLE only):
  - WR_EN writes {WR_X,WR_Y} to buf[wptr], then wptr++.
  - wptr saturates at NPTS; further writes are ignored.
  - WR_EN in any other state is ignored.
- START: accepted only in IDLE with wptr==NPTS. Otherwise ignored, with no flag.
  - Acceptance clears TMO and ERR.
  - Next state is LRST.
- LRST state: LRST=1 for exactly LRST_CYC cycles, then STREAM.
- STREAM:
  - LRST=0; cycle k (k=0..NPTS-1) drives LX/LY=buf[k], so point 0 appears the first cycle after LRST falls.
  - After NPTS cycles, go to RUN; LX/LY hold the last point.
  - If DONE_I==1 in any STREAM cycle: set ERR, pulse FIN, COVER=0, go to IDLE, wptr=0.
- RUN:
  - Cycle counter runs from 0.
  - DONE_I==1 captures C1/C2 into RES_* and moves to SCORE.
  - If the counter exceeds MAX_CYC before DONE: capture C*_I as-is, set TMO, go to SCORE.
- SCORE: one point per cycle, NPTS cycles.
  - dx, dy are signed 5-bit differences; d = dx²+dy², 8-bit unsigned.
  - A point counts as covered if d1<=16 or d2<=16; a point counts once even if covered by both.
  - COVER accumulates from 0.
- REPORT: one cycle. FIN=1, wptr=0, then IDLE. RES_* and COVER hold until the next accepted START.
- RST mid-run: returns to IDLE on the next edge and drops LRST, aborting LASER.

Optional Feature:
- LASER_HOST_CYCCNT_EN defined:
  - Adds output RUN_CYC [16:0], the number of RUN cycles from the first RUN cycle to DONE capture (saturates at MAX_CYC+1).
  - RUN_CYC is valid with FIN and reset to 0.
- Not defined: the port is absent; the RUN counter is used only for timeout.

Test Plan:
- Load 40 points all at (8,8); START. Model asserts DONE after 100 cycles with C1=(8,8), C2=(0,0). Required: LRST high exactly 2 cycles, LX/LY=8 for 40 cycles, FIN with COVER=40, RES_C1=(8,8), TMO=ERR=0.
- Points spread so that 12 lie within r=4 of (3,3) and 9 within r=4 of (12,12), disjoint; return those centres. Required: COVER=21.
- Boundary distance: point (7,3) vs C1=(3,3) (d=16) counts; point (7,4) (d=17) does not. Also return C1=C2 over 5 points. Required: no double count, COVER=5.
- DONE_I held high: at STREAM k=5 -> ERR=1, FIN pulse, COVER=0, IDLE. DONE never asserted -> TMO=1 after 50001 RUN cycles, with result scored from the current C*_I.
- START with only 39 points written -> ignored, BUSY stays 0. WR_EN during STREAM -> buffer unchanged on the next run.
- RST asserted mid-RUN -> all outputs at reset values next cycle. Then reload and rerun -> correct COVER. With LASER_HOST_CYCCNT_EN: DONE after 100 RUN cycles -> RUN_CYC=100.
